// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined unsigned Urdhva-Tiryakbhyam multiplier with valid/ready on both sides.
// Stages: half-products, cross-term sum, recombination. All additions use 4-bit CLA slices.

module vedic_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_p,
    output logic       o_g
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p    = i_a ^ i_b;
    assign w_g    = i_a & i_b;
    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign o_s    = w_p ^ w_c;
    assign o_p    = &w_p;
    assign o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module vedic_cla_add #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c,
    output logic [N-1:0] o_s,
    output logic         o_c
);
    localparam int unsigned NG = N / 4;

    logic [NG-1:0] w_gp;
    logic [NG-1:0] w_gg;
    logic [NG:0]   w_c;

    assign w_c[0] = i_c;

    // Group carries resolved from each slice's group propagate/generate.
    for (genvar g = 0; g < NG; g++) begin : g_slice
        vedic_cla4 u_slice (
            .i_a (i_a[4*g +: 4]),
            .i_b (i_b[4*g +: 4]),
            .i_c (w_c[g]),
            .o_s (o_s[4*g +: 4]),
            .o_p (w_gp[g]),
            .o_g (w_gg[g])
        );
        assign w_c[g+1] = w_gg[g] | (w_gp[g] & w_c[g]);
    end

    assign o_c = w_c[NG];
endmodule

module vedic_mul_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned UW = 2 * WIDTH - H;

    logic             r_v1, r_v2, r_v3;
    logic             w_adv1, w_adv2, w_adv3;
    logic [H-1:0]     w_al, w_ah, w_bl, w_bh;
    logic [WIDTH-1:0] r_ll1, r_lh1, r_hl1, r_hh1;
    logic [TAG_W-1:0] r_tag1, r_tag2;
    logic [WIDTH-1:0] r_ll2, r_hh2;
    logic [WIDTH:0]   r_mid2;
    logic [WIDTH:0]   w_mid;
    logic [UW-1:0]    w_hi_base, w_hi_mid, w_hi_sum;
    logic             w_unused_co;

    // Bubble-collapsing advance chain, combinational from out_ready.
    assign w_adv3    = !r_v3 || out_ready;
    assign w_adv2    = !r_v2 || w_adv3;
    assign w_adv1    = !r_v1 || w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_v3;
    assign busy      = r_v1 | r_v2 | r_v3;

    assign w_al = in_a[H-1:0];
    assign w_ah = in_a[WIDTH-1:H];
    assign w_bl = in_b[H-1:0];
    assign w_bh = in_b[WIDTH-1:H];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_ll1  <= '0;
            r_lh1  <= '0;
            r_hl1  <= '0;
            r_hh1  <= '0;
            r_tag1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_ll1  <= WIDTH'(w_al) * WIDTH'(w_bl);
                r_lh1  <= WIDTH'(w_al) * WIDTH'(w_bh);
                r_hl1  <= WIDTH'(w_ah) * WIDTH'(w_bl);
                r_hh1  <= WIDTH'(w_ah) * WIDTH'(w_bh);
                r_tag1 <= in_tag;
            end
        end
    end

    vedic_cla_add #(.N(WIDTH)) u_mid (
        .i_a (r_lh1),
        .i_b (r_hl1),
        .i_c (1'b0),
        .o_s (w_mid[WIDTH-1:0]),
        .o_c (w_mid[WIDTH])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_mid2 <= '0;
            r_ll2  <= '0;
            r_hh2  <= '0;
            r_tag2 <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_mid2 <= w_mid;
                r_ll2  <= r_ll1;
                r_hh2  <= r_hh1;
                r_tag2 <= r_tag1;
            end
        end
    end

    // Low H bits of LL pass straight through; MID (with its carry) lands from bit H upward.
    assign w_hi_base = {r_hh2, r_ll2[WIDTH-1:H]};
    assign w_hi_mid  = UW'(r_mid2);

    vedic_cla_add #(.N(UW)) u_fin (
        .i_a (w_hi_base),
        .i_b (w_hi_mid),
        .i_c (1'b0),
        .o_s (w_hi_sum),
        .o_c (w_unused_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            out_p   <= '0;
            out_tag <= '0;
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                out_p   <= {w_hi_sum, r_ll2[H-1:0]};
                out_tag <= r_tag2;
            end
        end
    end
endmodule

// File: doc/vedic_mul_pipe.md
Name: vedic_mul_pipe

Overview:
- Pipelined unsigned Vedic (Urdhva-Tiryakbhyam) multiplier.
- Each operand is split into high and low halves. The four half-products are summed by carry-lookahead addition built from the team's 4-bit CLA slices.
- Sits directly upstream of the CLA adder tree: it produces the partial products and the cross-term sums that the CLA slices consume.
- Provides valid/ready handshakes on both sides, so it can live inside a streaming datapath.

Parameters:
- WIDTH, 8, operand width. Must be a multiple of 8; 8 and 16 are supported. H = WIDTH/2.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts the pair this cycle.
- in_a  input  WIDTH  multiplicand, unsigned.
- in_b  input  WIDTH  multiplier, unsigned.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_p  output  2*WIDTH  product a*b.
- out_tag  output  TAG_W  tag of that product.
- busy  output  1  high if any pipeline stage holds a valid entry.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All stage valid bits clear.
  - out_valid=0, out_p=0, out_tag=0, busy=0.
  - in_ready follows its combinational equation, so it reads 1 while the pipe is empty.
  - Data registers other than the outputs need no reset.
- Stage S1, captured on in_valid && in_ready. Registers the half-products:
  - LL = aL*bL
  - LH = aL*bH
  - HL = aH*bL
  - HH = aH*bH
  - Each half-product is 2H bits wide. The tag is also registered.
- Stage S2:
  - MID = LH + HL, WIDTH+1 bits, carry kept.
  - LL and HH are forwarded unchanged. Tag forwarded.
- Stage S3:
  - P = (HH << WIDTH) + (MID << H) + LL, truncated to 2*WIDTH bits. No information is lost because a*b < 2^(2*WIDTH).
  - P drives out_p; out_valid is S3's valid bit.
- Adders: all additions use carry-lookahead composed of 4-bit CLA slices with group P/G. Behavioural "+" is not used.
- Latency: an accepted pair appears on out_p exactly 3 cycles after acceptance when never stalled. Throughput is 1 result per cycle.
- Flow control, bubble-collapsing:
  - Stage k advances when it is empty or stage k+1 advances.
  - S3 advances when it is empty or out_ready is high.
  - in_ready = S1 advance condition, i.e. !v1 || adv2. It is combinational from out_ready through the chain; this path is accepted.
- Handshake rules:
  - A stalled stage holds its data and tag stable.
  - out_p and out_tag must not change while out_valid && !out_ready.
  - Holding in_valid high with in_ready low loses nothing: the pair is taken on the first cycle in_ready is high.
  - Input and output handshakes may both fire in the same cycle. When the pipe is full and out_ready=1, in_ready=1 and a new pair enters S1 while S3 drains.
- Bubbles: an empty stage is filled even if the stage downstream of it is stalled. The pipe holds at most 3 entries.
- Results and tags leave in acceptance order.
- busy = v1 | v2 | v3.
- Reset asserted mid-operation: all in-flight entries are discarded and out_valid drops immediately, asynchronously. No partial result is ever emitted after rst_n rises.
- Boundaries:
  - A or B = 0 gives P = 0.
  - All-ones operands give P = 2^(2W) - 2^(W+1) + 1.
  - MID carry-out (bit WIDTH) must land at bit position WIDTH+H.

Test Plan:
- WIDTH=8, out_ready=1: a=0xFF, b=0xFF, tag=0x5 at cycle 0 -> out_valid at cycle 3, out_p=0xFE01, out_tag=0x5.
- Back-to-back stream (3,5), (0x80,0x02), (0,0xAB), (0x12,0x34) -> outputs on 4 consecutive cycles: 0x000F, 0x0100, 0x0000, 0x03A8, in order.
- Backpressure: fill the pipe with 3 ops, hold out_ready=0 for 5 cycles -> in_ready=0 once full; out_p stable; on release, 3 results in consecutive cycles with no loss or duplication.
- Bubble collapse: send 1 op, stall output, send a second op 2 cycles later -> second op advances to S2 behind the stalled S3. Both results emerge on consecutive cycles once out_ready=1.
- Reset mid-flight: 2 ops in the pipe, pulse rst_n low between clock edges -> out_valid=0 and busy=0 immediately; no stale result after release. A new op (7,9) yields 0x003F at latency 3.
- WIDTH=16, random 1000 pairs with random in_valid/out_ready -> every out_p equals a*b, tags match, ordering preserved.
